window_fetcher_fp: RTL

Streaming line-buffer window generator that sits directly upstream of the floating-point convolution stage. It accepts a raster-ordered pixel stream (one floating-point word per cycle, tagged with column/row) and emits, per accepted pixel, the full WINDOW_WIDTH x WINDOW_HEIGHT neighbourhood ending at that pixel, tagged with the window-centre coordinate. The block is format-agnostic: words are moved, never interpreted.

---
 rtl/window_fetcher_fp_if.sv | 25 ++
 rtl/window_fetcher_fp.sv | 87 ++++++++
 2 files changed

// File: rtl/window_fetcher_fp_if.sv
// Pixel-in / window-out bundle for window_fetcher_fp.
// The master drives pixels and observes windows; the slave is the fetcher.
interface window_fetcher_fp_if #(
  parameter int FP_WIDTH     = 32,
  parameter int LINEAR_WIDTH = 9
);
  logic [FP_WIDTH-1:0]              data_i;
  logic [15:0]                      col_i;
  logic [15:0]                      row_i;
  logic                             valid_i;
  logic [LINEAR_WIDTH*FP_WIDTH-1:0] window_o;
  logic [15:0]                      col_o;
  logic [15:0]                      row_o;
  logic                             valid_o;

  modport master (
    output data_i, col_i, row_i, valid_i,
    input  window_o, col_o, row_o, valid_o
  );

  modport slave (
    input  data_i, col_i, row_i, valid_i,
    output window_o, col_o, row_o, valid_o
  );
endinterface

// File: rtl/window_fetcher_fp.sv
// Line-buffer window generator: emits the WINDOW_WIDTH x WINDOW_HEIGHT neighbourhood
// ending at each accepted raster pixel, one cycle after it arrives. Words are opaque.
module window_fetcher_fp #(
  parameter int EXP_WIDTH     = 8,
  parameter int FRAC_WIDTH    = 23,
  parameter int WINDOW_WIDTH  = 3,
  parameter int WINDOW_HEIGHT = 3,
  parameter int IMAGE_WIDTH   = 640
) (
  input logic             clk_i,
  input logic             rst_i,
  window_fetcher_fp_if.slave io_bus
);
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int LINEAR_WIDTH = WINDOW_WIDTH * WINDOW_HEIGHT;
  localparam int IDX_W        = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [15:0] COL_OFF = 16'((WINDOW_WIDTH - 1) - WINDOW_WIDTH / 2);
  localparam logic [15:0] ROW_OFF = 16'((WINDOW_HEIGHT - 1) - WINDOW_HEIGHT / 2);
  localparam logic [15:0] COL_MIN = 16'(WINDOW_WIDTH - 1);
  localparam logic [15:0] ROW_MIN = 16'(WINDOW_HEIGHT - 1);
  localparam logic [15:0] IMG_W16 = 16'(IMAGE_WIDTH);

  logic [FP_WIDTH_REG-1:0] r_lb  [WINDOW_HEIGHT-1][IMAGE_WIDTH];
  logic [FP_WIDTH_REG-1:0] r_win [WINDOW_HEIGHT][WINDOW_WIDTH];
  logic [15:0]             r_col;
  logic [15:0]             r_row;
  logic                    r_valid;

  logic [FP_WIDTH_REG-1:0]              w_col [WINDOW_HEIGHT];
  logic [LINEAR_WIDTH*FP_WIDTH_REG-1:0] w_window;
  logic [IDX_W-1:0]                     w_idx;
  logic                                 w_accept;
  logic                                 w_emit;

  assign w_accept = io_bus.valid_i && (io_bus.col_i < IMG_W16);
  assign w_emit   = w_accept && (io_bus.col_i >= COL_MIN) && (io_bus.row_i >= ROW_MIN);
  assign w_idx    = io_bus.col_i[IDX_W-1:0];

  // Column vector entering the window: oldest line buffer on top, live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < WINDOW_HEIGHT; r++) w_col[r] = '0;
    w_col[WINDOW_HEIGHT-1] = io_bus.data_i;
    for (int r = 0; r < WINDOW_HEIGHT - 1; r++) w_col[r] = r_lb[WINDOW_HEIGHT-2-r][w_idx];
  end

  // Line buffers carry no reset so they can map onto RAM; stale rows are masked by row_i.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_lb[0][w_idx] <= io_bus.data_i;
      for (int k = 1; k < WINDOW_HEIGHT - 1; k++) r_lb[k][w_idx] <= r_lb[k-1][w_idx];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < WINDOW_HEIGHT; r++)
        for (int c = 0; c < WINDOW_WIDTH; c++) r_win[r][c] <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_emit;
      if (w_accept) begin
        for (int r = 0; r < WINDOW_HEIGHT; r++) begin
          for (int c = 0; c < WINDOW_WIDTH - 1; c++) r_win[r][c] <= r_win[r][c+1];
          r_win[r][WINDOW_WIDTH-1] <= w_col[r];
        end
      end
      if (w_emit) begin
        r_col <= io_bus.col_i - COL_OFF;
        r_row <= io_bus.row_i - ROW_OFF;
      end
    end
  end

  always_comb begin
    w_window = '0;
    for (int r = 0; r < WINDOW_HEIGHT; r++)
      for (int c = 0; c < WINDOW_WIDTH; c++)
        w_window[(r*WINDOW_WIDTH+c)*FP_WIDTH_REG +: FP_WIDTH_REG] = r_win[r][c];
  end

  assign io_bus.window_o = w_window;
  assign io_bus.col_o    = r_col;
  assign io_bus.row_o    = r_row;
  assign io_bus.valid_o  = r_valid;
endmodule
